// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-requester round-robin arbiter that feeds bytes to a UART
// transmitter. It issues a one-cycle start pulse and waits for the UART busy
// line to rise and then fall. If the line never rises, it gives up and flags
// an error.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | nothing in flight; may accept a byte if UART line is quiet
// ISSUE      | byte latched; uart_transmit high for this single cycle
// WAIT_START | waiting for uart_is_transmitting to rise, timer running
// WAIT_DONE  | UART busy; waiting for uart_is_transmitting to fall
module uart_tx_arb #(
  parameter int START_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_byte,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_byte,
  output logic        req1_ready,
  output logic        uart_transmit,
  output logic [7:0]  uart_tx_byte,
  input  logic        uart_is_transmitting,
  output logic        grant_id,
  output logic        busy,
  output logic        start_err,
  output logic [15:0] tx_count
);

  // Timer must be wide enough to reach START_TIMEOUT, never narrower than 8 bits.
  localparam int TW_NEED = $clog2(START_TIMEOUT + 1);
  localparam int TW      = (TW_NEED > 8) ? TW_NEED : 8;
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(START_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic            rr_ptr;
  logic [TW-1:0]   timer;
  logic            sel0;
  logic            sel1;
  logic            can_accept;

  // Requester selection: a lone valid requester wins, rr_ptr breaks ties.
  always_comb begin
    sel0       = req0_valid && (!req1_valid || !rr_ptr);
    sel1       = req1_valid && (!req0_valid ||  rr_ptr);
    // rst is included so that ready stays low while reset is held.
    can_accept = !rst && (state == IDLE) && !uart_is_transmitting;
  end

  assign req0_ready = can_accept && sel0;
  assign req1_ready = can_accept && sel1;
  assign busy       = (state != IDLE);

  // The error pulse must line up with the timeout cycle itself. It also has to
  // respect a UART that rises on that same cycle, so it cannot be registered.
  assign start_err  = (state == WAIT_START) && !uart_is_transmitting &&
                      (timer == TIMEOUT_VAL);

  // Main sequencing FSM with registered UART-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= 1'b0;
      timer         <= '0;
      uart_transmit <= 1'b0;
      uart_tx_byte  <= 8'h00;
      grant_id      <= 1'b0;
      tx_count      <= 16'h0000;
    end else begin
      uart_transmit <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid && req0_ready) begin
            uart_tx_byte  <= req0_byte;
            grant_id      <= 1'b0;
            uart_transmit <= 1'b1;
            state         <= ISSUE;
          end else if (req1_valid && req1_ready) begin
            uart_tx_byte  <= req1_byte;
            grant_id      <= 1'b1;
            uart_transmit <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (uart_is_transmitting) begin
            state <= WAIT_DONE;
          end else if (timer == TIMEOUT_VAL) begin
            rr_ptr <= ~grant_id;
            state  <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!uart_is_transmitting) begin
            tx_count <= tx_count + 16'd1;
            rr_ptr   <= ~grant_id;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: an idle-ready vector table plus
// directed sequences for transfer, contention, timeout, busy line, reset and wrap.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_byte  = 8'h00;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_byte  = 8'h00;
  logic        req1_ready;
  logic        uart_transmit;
  logic [7:0]  uart_tx_byte;
  logic        uart_is_transmitting;
  logic        grant_id;
  logic        busy;
  logic        start_err;
  logic [15:0] tx_count;

  logic model_busy  = 1'b0;
  logic manual_busy = 1'b0;
  logic uart_en     = 1'b0;
  int   busy_len    = 4;

  int checks = 0;
  int errors = 0;

  assign uart_is_transmitting = model_busy | manual_busy;

  uart_tx_arb #(.START_TIMEOUT(15)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req0_valid           (req0_valid),
    .req0_byte            (req0_byte),
    .req0_ready           (req0_ready),
    .req1_valid           (req1_valid),
    .req1_byte            (req1_byte),
    .req1_ready           (req1_ready),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .grant_id             (grant_id),
    .busy                 (busy),
    .start_err            (start_err),
    .tx_count             (tx_count)
  );

  always #5 clk = ~clk;

  // UART model: busy rises half a cycle after the start pulse is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_en && uart_transmit) begin
        model_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic v0;
    logic v1;
    logic ubusy;
    logic r0;
    logic r1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int tp, output int ep);
    logic done;
    done = 1'b0;
    tp = 0;
    ep = 0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      if (uart_transmit) tp++;
      if (start_err) ep++;
      if (!busy) done = 1'b1;
    end
    chk("wait_idle_done", done, 1);
  endtask

  initial begin
    int tp, ep, n, rc;
    logic found;
    logic [7:0] exp_byte;

    vecs[0] = '{v0:0, v1:0, ubusy:0, r0:0, r1:0};
    vecs[1] = '{v0:1, v1:0, ubusy:0, r0:1, r1:0};
    vecs[2] = '{v0:0, v1:1, ubusy:0, r0:0, r1:1};
    vecs[3] = '{v0:1, v1:1, ubusy:0, r0:1, r1:0};
    vecs[4] = '{v0:0, v1:0, ubusy:1, r0:0, r1:0};
    vecs[5] = '{v0:1, v1:0, ubusy:1, r0:0, r1:0};
    vecs[6] = '{v0:0, v1:1, ubusy:1, r0:0, r1:0};
    vecs[7] = '{v0:1, v1:1, ubusy:1, r0:0, r1:0};

    // Reset state, with both requesters valid while reset is held.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_xmit", uart_transmit, 0);
    chk("rst_byte", uart_tx_byte, 8'h00);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", start_err, 0);
    chk("rst_count", tx_count, 16'h0000);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rst = 1'b0;

    // Idle ready table, rr_ptr = 0 after reset. Inputs drop before the next edge.
    for (int i = 0; i < 8; i++) begin
      step();
      req0_valid  = vecs[i].v0;
      req1_valid  = vecs[i].v1;
      manual_busy = vecs[i].ubusy;
      #1;
      chk($sformatf("vec%0d_ready0", i), req0_ready, vecs[i].r0);
      chk($sformatf("vec%0d_ready1", i), req1_ready, vecs[i].r1);
      req0_valid  = 1'b0;
      req1_valid  = 1'b0;
      manual_busy = 1'b0;
    end

    // Single request, 160-cycle UART.
    uart_en  = 1'b1;
    busy_len = 160;
    step();
    req0_byte  = 8'hA5;
    req0_valid = 1'b1;
    #1;
    chk("single_ready0", req0_ready, 1);
    chk("single_ready1", req1_ready, 0);
    step();
    chk("single_xmit", uart_transmit, 1);
    chk("single_ready0_after", req0_ready, 0);
    req0_valid = 1'b0;
    wait_idle(400, tp, ep);
    chk("single_extra_xmit", tp, 0);
    chk("single_err", ep, 0);
    chk("single_count", tx_count, 16'd1);
    chk("single_grant", grant_id, 0);
    chk("single_byte", uart_tx_byte, 8'hA5);

    // Contention: alternating grants.
    do_reset();
    busy_len  = 4;
    req0_byte = 8'h11;
    req1_byte = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
        step();
        if (uart_transmit) found = 1'b1;
      end
      chk($sformatf("cont%0d_seen", k), found, 1);
      chk($sformatf("cont%0d_grant", k), grant_id, k % 2);
      exp_byte = (k % 2 == 0) ? 8'h11 : 8'h22;
      chk($sformatf("cont%0d_byte", k), uart_tx_byte, exp_byte);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle(100, tp, ep);
    chk("cont_count", tx_count, 16'd4);

    // Start timeout: UART never answers.
    do_reset();
    uart_en = 1'b0;
    req0_byte  = 8'h3C;
    req1_byte  = 8'h7E;
    req0_valid = 1'b1;
    step();
    chk("to_xmit", uart_transmit, 1);
    req0_valid = 1'b0;
    found = 1'b0;
    n = 0;
    for (int c = 1; c <= 40 && !found; c++) begin
      step();
      n = c;
      if (start_err) found = 1'b1;
    end
    chk("to_err_seen", found, 1);
    chk("to_err_cycle", n, 16);
    step();
    chk("to_err_single", start_err, 0);
    chk("to_idle", busy, 0);
    chk("to_count", tx_count, 16'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("to_next_ready0", req0_ready, 0);
    chk("to_next_ready1", req1_ready, 1);
    step();
    chk("to_next_xmit", uart_transmit, 1);
    chk("to_next_grant", grant_id, 1);
    chk("to_next_byte", uart_tx_byte, 8'h7E);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle(60, tp, ep);
    chk("to_second_err", ep, 1);
    chk("to_count2", tx_count, 16'd0);

    // Busy line while idle blocks acceptance.
    uart_en     = 1'b1;
    busy_len    = 3;
    manual_busy = 1'b1;
    req1_byte   = 8'h96;
    req1_valid  = 1'b1;
    rc = 0;
    repeat (6) begin
      step();
      if (req1_ready || busy) rc++;
    end
    chk("bl_blocked", rc, 0);
    manual_busy = 1'b0;
    #1;
    chk("bl_ready1", req1_ready, 1);
    step();
    chk("bl_xmit", uart_transmit, 1);
    chk("bl_grant", grant_id, 1);
    chk("bl_byte", uart_tx_byte, 8'h96);
    req1_valid = 1'b0;
    wait_idle(60, tp, ep);
    chk("bl_count", tx_count, 16'd1);

    // Async reset in WAIT_DONE.
    busy_len   = 20;
    req0_byte  = 8'h5A;
    req0_valid = 1'b1;
    step();
    chk("ar_xmit", uart_transmit, 1);
    req0_valid = 1'b0;
    repeat (5) step();
    chk("ar_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_xmit0", uart_transmit, 0);
    chk("ar_byte", uart_tx_byte, 8'h00);
    chk("ar_grant", grant_id, 0);
    chk("ar_count", tx_count, 16'd0);
    chk("ar_err", start_err, 0);
    ep = 0;
    repeat (2) begin
      step();
      if (start_err) ep++;
    end
    rst = 1'b0;
    step();
    chk("ar_first_idle", busy, 0);
    if (start_err) ep++;
    for (int c = 0; c < 60 && uart_is_transmitting; c++) begin
      step();
      if (start_err) ep++;
    end
    chk("ar_no_err", ep, 0);
    chk("ar_line_quiet", uart_is_transmitting, 0);

    // Counter wrap via a preloaded count.
    step();
    force dut.tx_count = 16'hFFFF;
    #1;
    release dut.tx_count;
    #1;
    chk("wrap_preload", tx_count, 16'hFFFF);
    busy_len   = 3;
    req0_byte  = 8'h01;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    wait_idle(60, tp, ep);
    chk("wrap_count", tx_count, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter START_TIMEOUT, default 15: cycles allowed in WAIT_START for uart_is_transmitting to rise.
REQ-002 clk  input  1  master clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has a byte to send.
REQ-005 req0_byte  input  8  requester 0 byte.
REQ-006 req0_ready  output  1  requester 0 byte accepted this cycle when req0_valid also high.
REQ-007 req1_valid, req1_byte, req1_ready: same as REQ-004..006 for requester 1.
REQ-008 uart_transmit  output  1  one-cycle start pulse to UART transmitter.
REQ-009 uart_tx_byte  output  8  byte presented to UART; held stable from ISSUE through WAIT_DONE.
REQ-010 uart_is_transmitting  input  1  UART transmit line busy.
REQ-011 grant_id  output  1  requester of the byte most recently accepted.
REQ-012 busy  output  1  high whenever state != IDLE.
REQ-013 start_err  output  1  one-cycle pulse on start timeout.
REQ-014 tx_count  output  16  count of successfully completed transfers.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-016 The selected requester SHALL be: the only valid one if exactly one is valid; rr_ptr if both are valid; none if neither is valid.
REQ-017 reqN_ready SHALL be combinational: high iff state==IDLE, uart_is_transmitting==0, and N is selected; at most one ready high per cycle.
REQ-018 On reqN_valid&&reqN_ready, reqN_byte SHALL be latched into uart_tx_byte, grant_id set to N, and the state SHALL go to ISSUE.
REQ-019 IDLE with uart_is_transmitting==1 SHALL accept nothing; with no valid requester, the state SHALL remain IDLE.
REQ-020 uart_transmit SHALL be high exactly during the single ISSUE cycle; ISSUE always goes to WAIT_START with the timer cleared to 0.
REQ-021 WAIT_START with uart_is_transmitting==1 SHALL go to WAIT_DONE.
REQ-022 Otherwise, WAIT_START SHALL increment the timer; on the cycle the timer equals START_TIMEOUT, it SHALL pulse start_err, go to IDLE, and set rr_ptr to ~grant_id; tx_count is unchanged.
REQ-023 WAIT_DONE with uart_is_transmitting==0 SHALL go to IDLE, increment tx_count (wrapping 16'hFFFF->0), and set rr_ptr to ~grant_id.
REQ-024 Latency SHALL be: acceptance cycle T, uart_transmit high at T+1, earliest next acceptance one cycle after uart_is_transmitting falls.
REQ-025 Byte changes on an unselected or non-ready requester SHALL have no effect; a requester may drop valid before acceptance without penalty.
REQ-026 Timer width SHALL hold START_TIMEOUT (8 bits minimum); START_TIMEOUT=0 SHALL time out on the first WAIT_START cycle unless uart_is_transmitting is high.

Reset
REQ-027 While rst is high, regardless of clk: state=IDLE, rr_ptr=0, timer=0, uart_transmit=0, uart_tx_byte=0, grant_id=0, start_err=0, tx_count=0.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer without a start_err pulse; the first cycle after deassertion is IDLE.
REQ-029 req0_ready and req1_ready SHALL be 0 during reset.

Verification
REQ-030 Single request: req0_valid=1, byte 8'hA5, UART model raises busy 1 cycle after pulse for 160 cycles -> req0_ready one cycle, uart_transmit one cycle, uart_tx_byte=8'hA5, tx_count=1, grant_id=0.
REQ-031 Contention: both valid continuously with bytes 8'h11/8'h22 for 4 transfers -> grants alternate 0,1,0,1, UART sees 11,22,11,22, tx_count=4.
REQ-032 Timeout: UART never raises busy, START_TIMEOUT=15 -> start_err pulses exactly 16 cycles after the uart_transmit cycle, state IDLE, tx_count unchanged, and the next grant goes to the other requester when both are valid.
REQ-033 Busy line at idle: uart_is_transmitting held 1 with req1_valid=1 -> req1_ready stays 0 until busy drops, then accepted the next cycle.
REQ-034 Async reset mid-WAIT_DONE: assert rst between clock edges -> all outputs reach reset values immediately, no start_err pulse, tx_count=0.
REQ-035 Wrap: preload via 65536 completed transfers (or force) -> tx_count wraps to 0.
